// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - immediate type codes shared by the imm_gen blocks
package imm_gen_pkg;

    localparam logic [2:0] IMM_I   = 3'd0;
    localparam logic [2:0] IMM_S   = 3'd1;
    localparam logic [2:0] IMM_B   = 3'd2;
    localparam logic [2:0] IMM_U   = 3'd3;
    localparam logic [2:0] IMM_J   = 3'd4;
    localparam logic [2:0] IMM_Z   = 3'd5;
    localparam logic [2:0] IMM_SH  = 3'd6;
    localparam logic [2:0] IMM_ILL = 3'd7;

    function automatic logic imm_type_legal(input logic [2:0] itype);
        return itype != IMM_ILL;
    endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// rtl/imm_gen_decode.sv - combinational instruction-word to immediate decoder
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      itype,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Every form is first assembled to 32 bits; zero-extended forms keep bit 31
    // clear so the final widening to XLEN can always be a sign extension.
    logic [31:0] field;
    logic        unused_opcode;

    assign unused_opcode = ^inst[6:0];

    always_comb begin
        field = '0;
        case (itype)
            IMM_I:   field = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   field = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   field = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   field = {inst[31:12], 12'b0};
            IMM_J:   field = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z:   field = {27'b0, inst[19:15]};
            IMM_SH:  field = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
            default: field = '0;
        endcase
    end

    assign err = !imm_type_legal(itype);
    assign imm = XLEN'($signed(field));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - elastic pipelined immediate generator with squash and occupancy count
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [31:0]                   in_inst,
    input  logic [2:0]                    in_type,
    input  logic                          squash,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [XLEN-1:0]               out_imm,
    output logic                          out_err,
    output logic [$clog2(STAGES+1)-1:0]   count
);

    localparam int CW = $clog2(STAGES + 1);

    typedef struct packed {
        logic            val;
        logic            err;
        logic [XLEN-1:0] imm;
    } stage_t;

    logic [XLEN-1:0]   dec_imm;
    logic              dec_err;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] acc;
    stage_t            st [STAGES];
    stage_t            last;

    imm_gen_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst (in_inst),
        .itype(in_type),
        .imm  (dec_imm),
        .err  (dec_err)
    );

    // A stage can take new content when empty or when everything ahead drains;
    // resolved back from the output so a streaming pipe never bubbles.
    always_comb begin : ready_chain
        logic nxt;
        nxt = out_rdy;
        for (int k = STAGES - 1; k >= 0; k--) begin
            nxt    = !vld[k] || nxt;
            acc[k] = nxt;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t src;

        if (k == 0) begin : g_head
            assign src = '{val: in_val, err: dec_err, imm: dec_imm};
        end else begin : g_body
            assign src = st[k-1];
        end

        assign vld[k] = st[k].val;

        always_ff @(posedge clk) begin
            if (reset) begin
                st[k] <= '0;
            end else if (squash) begin
                st[k].val <= 1'b0;
            end else if (acc[k]) begin
                st[k].val <= src.val;
                if (src.val) begin
                    st[k].imm <= src.imm;
                    st[k].err <= src.err;
                end
            end
        end
    end

    assign last    = st[STAGES-1];
    assign out_val = last.val && !squash;
    assign out_imm = last.imm;
    assign out_err = last.err;
    assign in_rdy  = acc[0] && !squash;

    always_comb begin
        count = '0;
        for (int k = 0; k < STAGES; k++) begin
            count = count + CW'(vld[k]);
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the decode-stage immediate generator.
- Covers all RV immediate formats plus CSR/shift forms, with a configurable XLEN sign-extension width.
- Adds a configurable-depth elastic val/rdy pipeline with whole-pipeline squash, an error flag for illegal types, and an occupancy counter.
- Sits between the fetch/decode buffer and the operand-select muxes in the datapath.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- STAGES, 2, number of register stages; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_val  in  1  input valid
- in_rdy  out  1  input ready
- in_inst  in  32  instruction word
- in_type  in  3  immediate type code
- squash  in  1  kill all in-flight entries (branch/jump redirect)
- out_val  out  1  output valid
- out_rdy  in  1  downstream ready
- out_imm  out  XLEN  generated immediate
- out_err  out  1  in_type was illegal for this entry
- count  out  $clog2(STAGES+1)  number of valid entries held

Behaviour:
- Single clock domain. Reset is synchronous and active-high: every stage valid bit is cleared and every data register is set to 0. After reset, out_val=0, out_imm=0, out_err=0, count=0, and in_rdy=1 (provided squash=0).
- Type codes:
  - 0 I: sext(inst[31:20])
  - 1 S: sext({inst[31:25],inst[11:7]})
  - 2 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0})
  - 3 U: sext({inst[31:12],12'b0})
  - 4 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0})
  - 5 Z (CSR zimm): zext(inst[19:15])
  - 6 SH (shamt): zext(inst[25:20]) for XLEN=64, zext(inst[24:20]) for XLEN=32
  - 7: illegal. imm=0 and err=1.
- sext replicates the MSB of the assembled field up to bit XLEN-1. No output is ever X.
- Decode is combinational at the input; its result is captured into stage 0 when the input transfer fires.
- Latency: STAGES cycles from input transfer to out_val, with no backpressure.
- Throughput: 1 per cycle.
- Each stage holds {val, imm, err}. out_* are driven directly from the last stage.
- Stage k may accept when it is empty or when its content moves on in the same cycle. The last stage moves on when out_val && out_rdy. Ready propagates combinationally backward, so full throughput holds under continuous out_rdy=1.
- in_rdy = stage-0 accept condition && !squash.
- Squash:
  - On a cycle with squash=1, out_val is forced to 0, so no output transfer occurs and in_rdy=0.
  - Next cycle, all valid bits are 0 and count=0.
  - Data registers may hold stale values; out_imm/out_err are don't-care while out_val=0.
- Full condition: all stages valid and out_rdy=0 gives in_rdy=0 and holds contents stable. out_imm/out_err must not change while out_val=1 && out_rdy=0.
- Full with out_rdy=1: simultaneous input and output transfers occur, and count is unchanged.
- Empty: out_val=0 and count=0. An input arriving into an empty pipe is visible after exactly STAGES cycles.
- count: +1 on input transfer, -1 on output transfer, unchanged on both or neither, and 0 after squash or reset. It saturates structurally at STAGES and never wraps.
- Reset asserted mid-operation has the same effect as squash plus clearing of data registers. Reset has priority over squash.

Decomposition:
- Package imm_gen_pkg holds:
  - the IMM_I … IMM_ILL 3-bit localparams
  - a typedef for the stage struct {val, err, imm}, parametrised by XLEN in the module
- One sub-module, imm_gen_decode: purely combinational (inst, type) → (imm[XLEN-1:0], err), parametrised by XLEN.
- The top level instantiates imm_gen_decode once, plus a generate loop of STAGES register stages.

Test Plan:
- I/S/U directed, XLEN=32, STAGES=2, out_rdy=1:
  - 0xFFF00093 type 0 → 0xFFFFFFFF
  - 0x0020A423 type 1 → 0x00000008
  - 0x123450B7 type 3 → 0x12345000
  - Each result appears exactly 2 cycles after input.
- B/J: 0xFE000EE3 type 2 → 0xFFFFFFFC; 0x001000EF type 4 → 0x00000800. Back-to-back inputs produce back-to-back outputs, with count steady at 2.
- XLEN=64: 0xFFF00093 type 0 → 0xFFFFFFFFFFFFFFFF. 0x03F0D093 type 6 → 0x3F. Type 5 on 0x000FD073 → 0x1F, zero-extended. Type 7 → imm 0, out_err=1.
- Backpressure, STAGES=2: hold out_rdy=0 and send 3 inputs. After 2 accepts, in_rdy=0 and count=2. out_imm stays stable for 5 cycles. Raising out_rdy drains both entries in order, and the third input is then accepted.
- Squash: fill the pipe (count=2) and pulse squash together with in_val=1. That cycle, in_rdy=0 and out_val=0. Next cycle, count=0 and out_val=0, and no squashed value is ever emitted.
- Reset mid-stream: assert reset for 1 cycle with count=2. Next cycle, out_val=0, out_imm=0, count=0, and in_rdy=1. A fresh input then completes with normal latency.
